// File: rtl/mod8_run_sched_pkg.sv
// rtl/mod8_run_sched_pkg.sv - shared types, defaults and round-robin pick for mod8_run_sched
// Contents:
//   state_t   : scheduler FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   DEF_NREQ  : default number of requesters
//   DEF_CW    : default counter width
//   rr_pick() : first set request bit searched cyclically from last+1
package mod8_run_sched_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_CW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Walks the n requesters starting just after 'last' and wrapping at n-1.
  // Returns 'last' when no bit is set; callers only use it when |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         n);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
      if (k <= n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod8_run_sched_if.sv
// rtl/mod8_run_sched_if.sv - requester/scheduler bundle for mod8_run_sched
// Signals:
//   req   : per-requester request level (master -> slave)
//   tgt   : packed per-requester terminal count, slice i at [i*CW +: CW]
//   pause : run freeze, only with MOD8_RUN_SCHED_PAUSE_EN defined
//   gnt   : one-hot grant (slave -> master)
//   busy  : run occupancy flag
//   count : shared counter value
//   done  : one-cycle completion pulse to the granted requester
// Modports: master = requester side, slave = scheduler side.
interface mod8_run_sched_if #(
  parameter int NREQ = 2,
  parameter int CW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] tgt;
`ifdef MOD8_RUN_SCHED_PAUSE_EN
  logic               pause;
`endif
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done;

`ifdef MOD8_RUN_SCHED_PAUSE_EN
  modport master (output req, tgt, pause, input gnt, busy, count, done);
  modport slave  (input req, tgt, pause, output gnt, busy, count, done);
`else
  modport master (output req, tgt, input gnt, busy, count, done);
  modport slave  (input req, tgt, output gnt, busy, count, done);
`endif
endinterface

// File: rtl/mod8_run_sched_ctr.sv
// rtl/mod8_run_sched_ctr.sv - CW-bit run counter with clear and enable
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   clr   : synchronous clear to 0 (priority over en)
//   en    : increment by one
//   count : current value
module mod8_run_ctr #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod8_run_sched.sv
// rtl/mod8_run_sched.sv - round-robin scheduler sharing one run counter
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mod8_run_sched_if.slave (req, tgt, [pause], gnt, busy, count, done)
// Config macro: MOD8_RUN_SCHED_PAUSE_EN adds the pause input that freezes RUN.
module mod8_run_sched
  import mod8_run_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  mod8_run_sched_if.slave      bus
);

  state_t          state, state_n;
  logic [CW-1:0]   tgt_q;
  logic [2:0]      last_ptr;
  logic [2:0]      win;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            ctr_clr;
  logic            ctr_en;
  logic            grant_go;
  logic            hold;

`ifdef MOD8_RUN_SCHED_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  assign win = rr_pick(8'(bus.req), last_ptr, NREQ);

  always_comb begin
    state_n  = state;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    grant_go = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          state_n  = ST_RUN;
          ctr_clr  = 1'b1;
          grant_go = 1'b1;
        end
      end
      ST_RUN: begin
        // A held cycle neither counts nor checks the terminal value.
        if (!hold) begin
          if (bus.count == tgt_q) state_n = ST_DONE;
          else                    ctr_en  = 1'b1;
        end
      end
      ST_DONE: begin
        // Count stays at tgt_q during DONE and returns to 0 on entering IDLE.
        state_n = ST_IDLE;
        ctr_clr = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      tgt_q    <= '0;
      last_ptr <= 3'(NREQ - 1);
    end else begin
      state  <= state_n;
      done_q <= (state == ST_RUN && state_n == ST_DONE) ? gnt_q : '0;
      if (grant_go) begin
        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
        tgt_q    <= bus.tgt[win*CW +: CW];
        last_ptr <= win;
      end else if (state == ST_DONE) begin
        gnt_q <= '0;
      end
    end
  end

  mod8_run_ctr #(.CW(CW)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .count (bus.count)
  );

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = (state != ST_IDLE);

endmodule
